// File: rtl/exp_sub_arbiter.sv
// -----------------------------------------------------------------------------
// exp_sub_arbiter
// Controller for the single shared exponent subtractor (Y = A - B) in the CORDIC
// coprocessor. The X-path and Y-path exponent scaling requests share the
// subtractor. This block picks one of them, registers its operands onto the
// subtractor inputs and captures the result. The result is returned through a
// valid/ready handshake together with an underflow flag.
//
// Parameters
//   W    exponent width (8 single, 11 double); width of subtractor A and Y
//   SAT  1: result clamps to 0 on underflow; 0: result is A-B mod 2^W
//
// Ports
//   clk, rst               clock (rising edge), asynchronous active-high reset
//   i_req_x/i_exp_x/i_shamt_x  X-path request and operands, held until o_gnt_x
//   i_req_y/i_exp_y/i_shamt_y  Y-path request and operands, held until o_gnt_y
//   o_gnt_x, o_gnt_y       one-cycle pulse: that requester's operands accepted
//   o_sub_a, o_sub_b       registered operands to the external subtractor
//   i_sub_y                subtractor result (combinational from o_sub_a/o_sub_b)
//   o_res_valid            result available
//   i_res_ready            consumer takes the result when valid & ready
//   o_res_exp              result exponent
//   o_res_id               owner of the result: 0 = X, 1 = Y
//   o_res_uflow            underflow: o_sub_a < zero-extended o_sub_b
// -----------------------------------------------------------------------------
module exp_sub_arbiter #(
  parameter int W   = 8,
  parameter bit SAT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_req_x,
  input  logic [W-1:0] i_exp_x,
  input  logic [4:0]   i_shamt_x,
  input  logic         i_req_y,
  input  logic [W-1:0] i_exp_y,
  input  logic [4:0]   i_shamt_y,
  output logic         o_gnt_x,
  output logic         o_gnt_y,
  output logic [W-1:0] o_sub_a,
  output logic [4:0]   o_sub_b,
  input  logic [W-1:0] i_sub_y,
  output logic         o_res_valid,
  input  logic         i_res_ready,
  output logic [W-1:0] o_res_exp,
  output logic         o_res_id,
  output logic         o_res_uflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic         w_take;
  logic         w_any;
  logic         w_pick_y;
  logic         w_uflow;
  logic         r_last;
  logic         r_win;
  logic [W-1:0] r_sub_a;
  logic [4:0]   r_sub_b;
  logic [W-1:0] r_res_exp;
  logic         r_res_id;
  logic         r_res_uflow;

  assign w_any = i_req_x | i_req_y;

  // Round-robin: on a tie the requester that was not granted last time wins.
  // r_last = 1 means Y was granted last, so X wins the tie.
  assign w_pick_y = i_req_y & (~i_req_x | ~r_last);

  assign w_uflow = (r_sub_a < {{(W-5){1'b0}}, r_sub_b});

  // Next-state logic. A new operation is accepted from IDLE, or straight out of
  // HOLD in the same edge that the consumer takes the previous result.
  always_comb begin
    w_next = r_state;
    w_take = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_take = 1'b1;
          w_next = CALC;
        end
      end
      CALC: begin
        w_next = HOLD;
      end
      HOLD: begin
        if (i_res_ready) begin
          if (w_any) begin
            w_take = 1'b1;
            w_next = CALC;
          end else begin
            w_next = IDLE;
          end
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Operand capture and arbitration pointer update on every grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last  <= 1'b1;
      r_win   <= 1'b0;
      r_sub_a <= '0;
      r_sub_b <= '0;
    end else if (w_take) begin
      r_last  <= w_pick_y;
      r_win   <= w_pick_y;
      r_sub_a <= w_pick_y ? i_exp_y : i_exp_x;
      r_sub_b <= w_pick_y ? i_shamt_y : i_shamt_x;
    end
  end

  // The subtractor settles during CALC. Its result is captured at the end of
  // CALC and held through HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_exp   <= '0;
      r_res_id    <= 1'b0;
      r_res_uflow <= 1'b0;
    end else if (r_state == CALC) begin
      r_res_exp   <= (SAT && w_uflow) ? '0 : i_sub_y;
      r_res_id    <= r_win;
      r_res_uflow <= w_uflow;
    end
  end

  assign o_gnt_x     = (r_state == CALC) & ~r_win;
  assign o_gnt_y     = (r_state == CALC) &  r_win;
  assign o_res_valid = (r_state == HOLD);
  assign o_sub_a     = r_sub_a;
  assign o_sub_b     = r_sub_b;
  assign o_res_exp   = r_res_exp;
  assign o_res_id    = r_res_id;
  assign o_res_uflow = r_res_uflow;

endmodule
